// File: rtl/buffer_ctrl.sv
// Input buffer controller for a wormhole router port.
// Manages the read/write pointers of an external flit RAM and locks the
// output port for the duration of a packet (head .. tail). Flits whose
// type shows they belong to no open packet are dropped with an err pulse.
module buffer_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int RAM_DEPTH  = 4,
    localparam int AW         = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_wr_en,
    output logic [AW-1:0]         ram_wr_addr,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  req,
    input  logic                  grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full,
    output logic                  err
);

    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        ACTIVE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            push;
    logic            pop;
    logic            buf_empty;
    logic            is_head;
    logic            is_tail;
    logic            unused_payload;

    // The payload bits only matter to the downstream datapath, not here.
    assign unused_payload = ^ram_rd_data;

    // Flit type lives in the two top bits: bit DW-2 marks a head, bit DW-1 a tail.
    assign is_head = ram_rd_data[DATA_WIDTH-2];
    assign is_tail = ram_rd_data[DATA_WIDTH-1];

    // Occupancy seen by the outside world reads as cleared while reset is held.
    assign buf_empty = (count_q == '0);
    assign count     = reset ? '0 : count_q;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);

    // Write side: accept whenever there is room; reset suppresses the write.
    assign in_ready    = !full;
    assign push        = in_valid && in_ready && !reset;
    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;

    // Read side: the RAM shows the front flit combinationally at rd_ptr.
    assign ram_rd_addr = rd_ptr;
    assign ram_rd_en   = pop;

    // Pointer, occupancy and FSM state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet FSM: route on a head, hold the port lock until the tail leaves.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        out_valid = 1'b0;
        pop       = 1'b0;
        err       = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (!buf_empty) begin
                        if (is_head) begin
                            state_d = ROUTE;
                        end else begin
                            pop = 1'b1;
                            err = 1'b1;
                        end
                    end
                end
                ROUTE: begin
                    req = 1'b1;
                    if (grant) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    req       = 1'b1;
                    out_valid = !buf_empty;
                    pop       = out_valid && out_ready;
                    if (pop && is_tail) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
